rrf_alloc: RTL and testbench

RRF_ALLOC -- requirements
Module: rrf_alloc

---
 rtl/rrf_alloc.sv | 119 +++++++++++
 tb/tb_rrf_alloc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_alloc.sv
// Rename-register-file tag allocator: circular aptr/cptr pair with a used count.
// Define RRF_ALLOC_STATS_EN to add the stall counter and high-water-mark outputs.
module rrf_alloc #(
    parameter int RRF_ENT_NUM = 64,
    parameter int RRF_ENT_SEL = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_dp_req_1,
    input  logic                   i_dp_req_2,
    output logic [RRF_ENT_SEL-1:0] o_dp_rrftag_1,
    output logic [RRF_ENT_SEL-1:0] o_dp_rrftag_2,
    output logic                   o_dp_stall,
    input  logic                   i_com_en_1,
    input  logic                   i_com_en_2,
    output logic                   o_com_vld_1,
    output logic                   o_com_vld_2,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr_1,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr_2,
    input  logic                   i_flush,
    output logic [RRF_ENT_SEL:0]   o_free_cnt,
`ifdef RRF_ALLOC_STATS_EN
    output logic [31:0]            o_stall_cnt,
    output logic [RRF_ENT_SEL:0]   o_hwm,
`endif
    output logic                   o_full,
    output logic                   o_empty
);

    localparam logic [RRF_ENT_SEL:0] LP_N = (RRF_ENT_SEL+1)'(RRF_ENT_NUM);

    logic [RRF_ENT_SEL-1:0] r_aptr;
    logic [RRF_ENT_SEL-1:0] r_cptr;
    logic [RRF_ENT_SEL:0]   r_used;

    logic [1:0]             w_need;
    logic [1:0]             w_alloc;
    logic [1:0]             w_com_cnt;
    logic [RRF_ENT_SEL:0]   w_free;
    logic                   w_stall;
    logic                   w_com_vld_1;
    logic                   w_com_vld_2;
    logic [RRF_ENT_SEL-1:0] w_aptr_nxt;
    logic [RRF_ENT_SEL-1:0] w_cptr_nxt;
    logic [RRF_ENT_SEL:0]   w_used_nxt;

    // Slot 2 only counts when slot 1 also requests; dispatch is in-order.
    assign w_need = {1'b0, i_dp_req_1} + {1'b0, i_dp_req_1 & i_dp_req_2};
    assign w_free = LP_N - r_used;

    // Stall uses start-of-cycle occupancy only, so commits never feed the stall path.
    assign w_stall = i_flush | ((RRF_ENT_SEL+1)'(w_need) > w_free);
    assign w_alloc = w_stall ? 2'd0 : w_need;

    assign w_com_vld_1 = i_com_en_1 & (r_used != '0);
    assign w_com_vld_2 = i_com_en_1 & i_com_en_2 & (r_used >= (RRF_ENT_SEL+1)'(2));
    assign w_com_cnt   = {1'b0, w_com_vld_1} + {1'b0, w_com_vld_2};

    // Flush rewinds aptr to the post-commit cptr so retiring entries stay retired.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_cptr_nxt = r_cptr + RRF_ENT_SEL'(w_com_cnt);
        w_aptr_nxt = r_aptr + RRF_ENT_SEL'(w_alloc);
        w_used_nxt = r_used + (RRF_ENT_SEL+1)'(w_alloc) - (RRF_ENT_SEL+1)'(w_com_cnt);
        if (i_flush) begin
            w_aptr_nxt = w_cptr_nxt;
            w_used_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_aptr <= '0;
            r_cptr <= '0;
            r_used <= '0;
        end else begin
            r_aptr <= w_aptr_nxt;
            r_cptr <= w_cptr_nxt;
            r_used <= w_used_nxt;
        end
    end

`ifdef RRF_ALLOC_STATS_EN
    logic [31:0]          r_stall_cnt;
    logic [RRF_ENT_SEL:0] r_hwm;
    logic                 w_stall_evt;

    // Only genuine resource stalls count; flush-forced stalls are not back-pressure.
    assign w_stall_evt = w_stall & (w_need != 2'd0) & ~i_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_hwm       <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_used_nxt > r_hwm)
                r_hwm <= w_used_nxt;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_hwm       = r_hwm;
`endif

    assign o_dp_rrftag_1 = r_aptr;
    assign o_dp_rrftag_2 = r_aptr + RRF_ENT_SEL'(1);
    assign o_dp_stall    = w_stall;
    assign o_com_ptr_1   = r_cptr;
    assign o_com_ptr_2   = r_cptr + RRF_ENT_SEL'(1);
    assign o_com_vld_1   = w_com_vld_1;
    assign o_com_vld_2   = w_com_vld_2;
    assign o_free_cnt    = w_free;
    assign o_full        = (r_used == LP_N);
    assign o_empty       = (r_used == '0);

endmodule

// File: tb/tb_rrf_alloc.sv
// Directed-vector bench for rrf_alloc (N=64): reset, fill, stall, wrap, commit, flush.
module tb_rrf_alloc;

    localparam int N   = 64;
    localparam int SEL = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_1, req_2, com_en_1, com_en_2, flush;
    logic [SEL-1:0] tag_1, tag_2, com_ptr_1, com_ptr_2;
    logic           stall, com_vld_1, com_vld_2, full, empty;
    logic [SEL:0]   free_cnt;
`ifdef RRF_ALLOC_STATS_EN
    logic [31:0]    stall_cnt;
    logic [SEL:0]   hwm;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rrf_alloc #(.RRF_ENT_NUM(N), .RRF_ENT_SEL(SEL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_dp_req_1   (req_1),
        .i_dp_req_2   (req_2),
        .o_dp_rrftag_1(tag_1),
        .o_dp_rrftag_2(tag_2),
        .o_dp_stall   (stall),
        .i_com_en_1   (com_en_1),
        .i_com_en_2   (com_en_2),
        .o_com_vld_1  (com_vld_1),
        .o_com_vld_2  (com_vld_2),
        .o_com_ptr_1  (com_ptr_1),
        .o_com_ptr_2  (com_ptr_2),
        .i_flush      (flush),
        .o_free_cnt   (free_cnt),
`ifdef RRF_ALLOC_STATS_EN
        .o_stall_cnt  (stall_cnt),
        .o_hwm        (hwm),
`endif
        .o_full       (full),
        .o_empty      (empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow another unit later.
    task automatic drive(input logic r1, input logic r2, input logic c1, input logic c2, input logic fl);
        req_1 = r1; req_2 = r2; com_en_1 = c1; com_en_2 = c2; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 1);
        tick();
        tick();
        rst_n = 1'b1;
        drive(0, 0, 1, 1, 0);
        check("rst_tag1", 32'(tag_1), 0);
        check("rst_tag2", 32'(tag_2), 1);
        check("rst_cptr1", 32'(com_ptr_1), 0);
        check("rst_cptr2", 32'(com_ptr_2), 1);
        check("rst_vld1_gated", 32'(com_vld_1), 0);
        check("rst_vld2_gated", 32'(com_vld_2), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_free", 32'(free_cnt), 64);
        check("rst_stall", 32'(stall), 0);
`ifdef RRF_ALLOC_STATS_EN
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_hwm", 32'(hwm), 0);
`endif
        tick();

        // Three dual allocations from reset
        drive(1, 1, 0, 0, 0);
        check("a0_tag1", 32'(tag_1), 0);
        check("a0_tag2", 32'(tag_2), 1);
        tick();
        check("a1_tag1", 32'(tag_1), 2);
        check("a1_tag2", 32'(tag_2), 3);
        tick();
        check("a2_tag1", 32'(tag_1), 4);
        check("a2_tag2", 32'(tag_2), 5);
        tick();
        drive(0, 0, 0, 0, 0);
        check("a3_free", 32'(free_cnt), 58);
        check("a3_empty", 32'(empty), 0);

        // Fill to 63 entries
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 28; i++) tick();
        drive(1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0);
        check("u63_free", 32'(free_cnt), 1);
        check("u63_tag1", 32'(tag_1), 63);
        check("u63_dual_stall", 32'(stall), 1);
        tick();
        drive(1, 0, 0, 0, 0);
        check("u63_nochange_tag", 32'(tag_1), 63);
        check("u63_nochange_free", 32'(free_cnt), 1);
        check("u63_single_ok", 32'(stall), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("full_flag", 32'(full), 1);
        check("full_free", 32'(free_cnt), 0);
        check("full_tag_wrap", 32'(tag_1), 0);

        // Full: two commits plus two requests still stall
        drive(1, 1, 1, 1, 0);
        check("fc_stall", 32'(stall), 1);
        check("fc_vld1", 32'(com_vld_1), 1);
        check("fc_vld2", 32'(com_vld_2), 1);
        check("fc_cptr1", 32'(com_ptr_1), 0);
        check("fc_cptr2", 32'(com_ptr_2), 1);
        tick();
        drive(1, 1, 0, 0, 0);
        check("fc_free_after", 32'(free_cnt), 2);
        check("fc_full_after", 32'(full), 0);
        check("fc_cptr_after", 32'(com_ptr_1), 2);
        check("fc_alloc_ok", 32'(stall), 0);
        check("fc_alloc_tag1", 32'(tag_1), 0);
        check("fc_alloc_tag2", 32'(tag_2), 1);
        tick();
        drive(1, 0, 0, 0, 0);
        check("refull", 32'(full), 1);
        for (int i = 0; i < 3; i++) begin
            check("full_single_stall", 32'(stall), 1);
            tick();
        end
`ifdef RRF_ALLOC_STATS_EN
        check("stats_stall_cnt5", stall_cnt, 5);
        check("stats_hwm64", 32'(hwm), 64);
`endif

        // Flush an idle full queue, then build used=10, cptr=5
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        check("fl0_empty", 32'(empty), 1);
        check("fl0_tag1", 32'(tag_1), 2);
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        drive(1, 0, 1, 1, 0);
        check("mix_vld1", 32'(com_vld_1), 1);
        check("mix_vld2", 32'(com_vld_2), 1);
        check("mix_cptr1", 32'(com_ptr_1), 2);
        tick();
        drive(0, 0, 1, 0, 0);
        check("mix_free", 32'(free_cnt), 64 - 11);
        check("mix_tag1", 32'(tag_1), 15);
        check("c1_vld2_off", 32'(com_vld_2), 0);
        tick();
        drive(1, 1, 1, 0, 1);
        check("fl_pre_free", 32'(free_cnt), 54);
        check("fl_stall", 32'(stall), 1);
        check("fl_vld1", 32'(com_vld_1), 1);
        check("fl_vld2", 32'(com_vld_2), 0);
        check("fl_cptr1", 32'(com_ptr_1), 5);
        tick();
        drive(0, 0, 0, 0, 0);
        check("fl_aptr", 32'(tag_1), 6);
        check("fl_cptr", 32'(com_ptr_1), 6);
        check("fl_empty", 32'(empty), 1);
        check("fl_free", 32'(free_cnt), 64);
`ifdef RRF_ALLOC_STATS_EN
        check("stats_flush_not_counted", stall_cnt, 5);
`endif

        // Move both pointers to 62 with the queue empty
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 28; i++) tick();
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 28; i++) tick();
        drive(1, 1, 0, 0, 0);
        check("wr_empty", 32'(empty), 1);
        check("wr_cptr", 32'(com_ptr_1), 62);
        check("wr_tag1", 32'(tag_1), 62);
        check("wr_tag2", 32'(tag_2), 63);
        tick();
        check("wr_tag1b", 32'(tag_1), 0);
        check("wr_tag2b", 32'(tag_2), 1);
        tick();
        drive(0, 0, 1, 1, 0);
        check("wr_free", 32'(free_cnt), 60);
        check("wr_cptr1", 32'(com_ptr_1), 62);
        check("wr_cptr2", 32'(com_ptr_2), 63);
        check("wr_vld2", 32'(com_vld_2), 1);
        tick();
        drive(0, 1, 0, 1, 0);
        check("wr_cptr_wrap", 32'(com_ptr_1), 0);
        check("wr_free2", 32'(free_cnt), 62);
        check("req2_alone_nostall", 32'(stall), 0);
        check("com2_alone_vld", 32'(com_vld_2), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("req2_alone_tag", 32'(tag_1), 2);
        check("com2_alone_cptr", 32'(com_ptr_1), 0);

        // Reset overrides a concurrent flush/alloc/commit
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 1);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("rst2_tag1", 32'(tag_1), 0);
        check("rst2_cptr1", 32'(com_ptr_1), 0);
        check("rst2_free", 32'(free_cnt), 64);
        check("rst2_empty", 32'(empty), 1);
`ifdef RRF_ALLOC_STATS_EN
        check("rst2_stall_cnt", stall_cnt, 0);
        check("rst2_hwm", 32'(hwm), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
